// File: rtl/fe_trigger_tagger.sv
// fe_trigger_tagger: inserts one header word per trigger edge into the
// FE-RX data stream ahead of any further data, buffered in a small
// first-word-fall-through FIFO.
module fe_trigger_tagger #(
  parameter int         DEPTH     = 8,
  parameter logic [3:0] HEADER_ID = 4'b1000
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  input  logic        ENABLE,
  input  logic        TRIG,
  input  logic        CNT_RESET,
  input  logic        IN_EMPTY,
  input  logic [31:0] IN_DATA,
  output logic        IN_READ,
  input  logic        OUT_READ,
  output logic        OUT_EMPTY,
  output logic [31:0] OUT_DATA,
  output logic [23:0] TRIG_CNT,
  output logic        TRIG_DROP
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          trig_q;
  logic          pend_q, pend_d;
  logic [31:0]   hdr_q, hdr_d;
  logic [23:0]   cnt_q, cnt_d;
  logic          drop_q, drop_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   mem [DEPTH];

  logic          has_space;
  logic          trig_edge;
  logic          wr_en;
  logic          wr_hdr;
  logic [31:0]   wr_data;
  logic          pop;
  logic [23:0]   cnt_inc;

  // Space is judged on the registered count, before any same-cycle pop.
  assign has_space = (count_q < CW'(DEPTH));
  assign trig_edge = TRIG & ~trig_q & ENABLE & ~CNT_RESET;
  assign cnt_inc   = cnt_q + 24'd1;

  // A pending header always wins the single write slot over upstream data.
  assign wr_hdr  = has_space & pend_q;
  assign IN_READ = BUS_RST_N & ~pend_q & ~IN_EMPTY & has_space;
  assign wr_en   = wr_hdr | IN_READ;
  assign wr_data = pend_q ? hdr_q : IN_DATA;
  assign pop     = OUT_READ & (count_q != '0);

  assign OUT_EMPTY = (count_q == '0);
  assign OUT_DATA  = OUT_EMPTY ? 32'd0 : mem[rd_ptr_q];
  assign TRIG_CNT  = cnt_q;
  assign TRIG_DROP = drop_q;

  // Trigger counter, pending header and drop flag next-state.
  always_comb begin
    pend_d = pend_q;
    hdr_d  = hdr_q;
    cnt_d  = cnt_q;
    drop_d = drop_q;
    if (CNT_RESET) begin
      pend_d = 1'b0;
      cnt_d  = '0;
      drop_d = 1'b0;
    end else if (trig_edge) begin
      cnt_d = cnt_inc;
      // The slot frees this cycle if the old header is being written.
      if (!pend_q || wr_hdr) begin
        pend_d = 1'b1;
        hdr_d  = {HEADER_ID, 4'h0, cnt_inc};
      end else begin
        drop_d = 1'b1;
      end
    end else if (wr_hdr) begin
      pend_d = 1'b0;
    end
  end

  // Control and pointer state, cleared asynchronously.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      trig_q   <= 1'b0;
      pend_q   <= 1'b0;
      hdr_q    <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      trig_q <= TRIG;
      pend_q <= pend_d;
      hdr_q  <= hdr_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Buffer storage; contents need no reset since the count gates visibility.
  always_ff @(posedge BUS_CLK) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: doc/fe_trigger_tagger.md
# fe_trigger_tagger

Inserts trigger header words into the FE-RX data stream. Sits between the FE receiver's FIFO read port and the round-robin arbiter input. It pops 32-bit data words from the receiver FIFO and counts trigger edges. Before forwarding further data it writes one header word per trigger into a small first-word-fall-through output buffer, so the host sees trigger-delimited events.

## Interface
Parameters:
- DEPTH, 8 — output buffer entries; power of 2, minimum 2
- HEADER_ID, 4'b1000 — placed in header bits [31:28]; must differ from RX (4'b0000) and TDC (4'b0100) identifiers

Ports:
- BUS_CLK  in  1  — single clock for all logic
- BUS_RST_N  in  1  — reset, asynchronous, active-low
- ENABLE  in  1  — when 0, trigger edges are ignored; data still passes through
- TRIG  in  1  — trigger level, already synchronous to BUS_CLK; rising edge = one trigger
- CNT_RESET  in  1  — synchronous clear of counter, pending header and TRIG_DROP
- IN_EMPTY  in  1  — upstream FWFT FIFO empty
- IN_DATA  in  32  — upstream head word, valid when !IN_EMPTY
- IN_READ  out  1  — pop upstream head word this cycle
- OUT_READ  in  1  — downstream pop; ignored when OUT_EMPTY
- OUT_EMPTY  out  1  — output buffer empty
- OUT_DATA  out  32  — output head word, valid when !OUT_EMPTY
- TRIG_CNT  out  24  — triggers counted since reset or CNT_RESET
- TRIG_DROP  out  1  — sticky; a trigger arrived while a header was still pending

## Operation
- Edge detect: trig_d is a register of TRIG. edge = TRIG & !trig_d & ENABLE & !CNT_RESET.
- On edge: TRIG_CNT <= TRIG_CNT+1, wrapping from 24'hFFFFFF to 0.
  - If no header is pending: set pending and latch hdr = {HEADER_ID, 4'h0, TRIG_CNT+1}.
  - If a header is already pending: set TRIG_DROP. The pending hdr value is kept.
- Write arbitration. State PEND = pending flag. At most one buffer write per cycle, and only if the buffer count < DEPTH, evaluated before any same-cycle pop.
  - PEND=1: write hdr, clear PEND.
  - If an edge occurs in the same cycle, PEND stays 1 with the new hdr value, and TRIG_DROP is not set.
  - PEND=0 and !IN_EMPTY: IN_READ=1; write IN_DATA unmodified.
  - Otherwise: no write.
- IN_READ = BUS_RST_N & !PEND & !IN_EMPTY & (count < DEPTH). It is combinational and must never assert while IN_EMPTY=1.
- Output buffer:
  - Circular, with wrapping read and write pointers and a count of width clog2(DEPTH)+1.
  - A simultaneous write and pop leaves count unchanged.
  - A pop when OUT_EMPTY=1 has no effect.
- CNT_RESET takes priority over an edge in the same cycle. It clears TRIG_CNT, PEND and TRIG_DROP. Buffer contents and pointers are kept, and a data write may still occur in that cycle.
- Asserting BUS_RST_N low mid-operation clears everything immediately, including buffer pointers. Buffered words are lost.

## Timing
- Reset values:
  - IN_READ=0, OUT_EMPTY=1, OUT_DATA=0, TRIG_CNT=0, TRIG_DROP=0
  - PEND=0, trig_d=0, pointers and count 0
- Data latency:
  - Upstream word popped in cycle M (IN_READ=1) gives OUT_EMPTY=0 in cycle M+1, with OUT_DATA equal to that word if the buffer was empty.
  - Sustained throughput is 1 word/cycle when no headers are pending and the downstream reads continuously.
- Trigger latency:
  - TRIG rises in cycle N: TRIG_CNT and PEND update at the end of N, and the header is written in N+1.
  - With an empty buffer, OUT_EMPTY=0 in N+2 with OUT_DATA=header.
  - Each header costs exactly one data slot.
- Full buffer: no write and IN_READ=0. PEND is held until space exists.
- OUT_DATA shows the entry at the read pointer. It is checked only while !OUT_EMPTY.

## Test plan
- **Reset and pass-through:** ENABLE=0; push 0x00000001..0x00000005 upstream; OUT_READ held 1.
  - OUT_DATA sequence is 1..5, no headers, TRIG_CNT=0.
  - Each word appears one cycle after its IN_READ.
- **Header insertion:** ENABLE=1; upstream empty; TRIG rises at cycle 10.
  - TRIG_CNT=1 at 11; OUT_EMPTY=0 at 12 with OUT_DATA=0x80000001.
  - Pending data words follow the header, with no reordering.
- **Backpressure:** DEPTH=8; OUT_READ=0; 12 upstream words; one trigger after the 8th word is written.
  - Buffer fills and IN_READ drops after 8 pops.
  - Set OUT_READ=1: output is words 1..8, then header 0x80000001, then words 9..12.
- **Drop and counter:**
  - Fill the buffer with OUT_READ=0, then give two trigger edges 4 cycles apart. Expect TRIG_CNT=2, TRIG_DROP=1, and the drained header equal to 0x80000001 only.
  - Pulse CNT_RESET: TRIG_CNT=0, TRIG_DROP=0.
- **Wrap and simultaneous events:**
  - Preload TRIG_CNT near wrap via 2^24-1 edges (or force), then one more edge: TRIG_CNT=0, header=0x80000000.
  - An edge in the same cycle as CNT_RESET leaves TRIG_CNT=0.
  - Asserting BUS_RST_N low mid-burst gives OUT_EMPTY=1 and IN_READ=0 immediately.
